// File: rtl/inst_rom_srv_pkg.sv
// Shared constants, state encoding and byte-placement helper for inst_rom_srv.
package inst_rom_srv_pkg;

    localparam int InstBusW     = 32;
    localparam int InstAddrBusW = 32;

    localparam logic [InstBusW-1:0] ZeroWord = '0;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        DONE = 2'd1,
        RUN  = 2'd2
    } rom_state_e;

    // Big-endian slot: byte 0 lands in [31:24], byte 3 in [7:0].
    function automatic logic [InstBusW-1:0] place_byte(
        input logic [InstBusW-1:0] w,
        input logic [7:0]          b,
        input logic [1:0]          idx
    );
        logic [InstBusW-1:0] r;
        r = w;
        unique case (idx)
            2'd0: r[31:24] = b;
            2'd1: r[23:16] = b;
            2'd2: r[15:8]  = b;
            2'd3: r[7:0]   = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inst_rom_srv_byte_packer.sv
// Packs loader bytes into 32-bit words; a last flag zero-fills the rest.
module rom_byte_packer
    import inst_rom_srv_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,
    input  logic                i_xfer,
    input  logic [7:0]          i_byte,
    input  logic                i_last,
    output logic [InstBusW-1:0] o_word,
    output logic                o_word_we
);

    logic [1:0]          r_cnt;
    logic [InstBusW-1:0] r_shift;
    logic [InstBusW-1:0] w_word;

    assign w_word    = place_byte(r_shift, i_byte, r_cnt);
    assign o_word    = w_word;
    assign o_word_we = i_xfer && ((r_cnt == 2'd3) || i_last);

    // Unfilled low bytes stay zero because the shift is cleared per word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 2'd0;
            r_shift <= '0;
        end else if (i_clr || o_word_we) begin
            r_cnt   <= 2'd0;
            r_shift <= '0;
        end else if (i_xfer) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= w_word;
        end
    end

endmodule

// File: rtl/inst_rom_srv.sv
// Instruction ROM responder with byte-stream loader and core reset hold.
// Optional ROM_RELOAD_EN: reload_req_i in RUN returns to LOAD for a new image.
module inst_rom_srv
    import inst_rom_srv_pkg::*;
#(
    parameter int                  ADDR_W   = 10,
    parameter logic [InstBusW-1:0] NOP_WORD = ZeroWord
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rom_ce_i,
    input  logic [InstAddrBusW-1:0] rom_addr_i,
    output logic [InstBusW-1:0]     rom_data_o,
    input  logic                    load_valid_i,
    input  logic [7:0]              load_byte_i,
    input  logic                    load_last_i,
    output logic                    load_ready_o,
    input  logic                    reload_req_i,
    output logic                    cpu_rst_o,
    output logic                    load_done_o,
    output logic                    fetch_err_o
);

    localparam int DEPTH = 1 << ADDR_W;

    rom_state_e          r_state;
    rom_state_e          w_state_nxt;
    logic [ADDR_W-1:0]   r_word_cnt;
    logic [InstBusW-1:0] r_mem [DEPTH];
    logic                r_ferr;

    logic                w_xfer;
    logic                w_reload;
    logic [InstBusW-1:0] w_word;
    logic                w_word_we;
    logic [ADDR_W-1:0]   w_idx;
    logic                w_oob;
    logic                w_run;
    logic                w_unused;

`ifdef ROM_RELOAD_EN
    assign w_reload = (r_state == RUN) && reload_req_i;
    assign w_unused = ^rom_addr_i[1:0];
`else
    assign w_reload = 1'b0;
    assign w_unused = ^{rom_addr_i[1:0], reload_req_i};
`endif

    assign w_run        = (r_state == RUN);
    assign load_ready_o = (r_state == LOAD);
    assign w_xfer       = load_valid_i && load_ready_o;
    assign cpu_rst_o    = !w_run;
    assign load_done_o  = w_run;
    assign fetch_err_o  = r_ferr;

    rom_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_reload),
        .i_xfer    (w_xfer),
        .i_byte    (load_byte_i),
        .i_last    (load_last_i),
        .o_word    (w_word),
        .o_word_we (w_word_we)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= LOAD;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            LOAD: begin
                if (w_xfer && load_last_i)
                    w_state_nxt = DONE;
                else if (w_word_we && (&r_word_cnt))
                    w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = RUN;
            RUN:     if (w_reload) w_state_nxt = LOAD;
            default: w_state_nxt = LOAD;
        endcase
    end

    // Wraps to zero on a full image, which is also the exit condition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_word_cnt <= '0;
        else if (w_reload)  r_word_cnt <= '0;
        else if (w_word_we) r_word_cnt <= r_word_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_word_we) r_mem[r_word_cnt] <= w_word;
    end

    assign w_idx = rom_addr_i[ADDR_W+1:2];
    assign w_oob = |rom_addr_i[InstAddrBusW-1:ADDR_W+2];

    always_comb begin
        rom_data_o = NOP_WORD;
        if (rom_ce_i && w_run && !w_oob)
            rom_data_o = r_mem[w_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ferr <= 1'b0;
        else if (rom_ce_i && w_run && w_oob)
            r_ferr <= 1'b1;
    end

endmodule

// File: tb/tb_inst_rom_srv.sv
// Scoreboard bench for inst_rom_srv.
// Full-size and ADDR_W=2 instances.
module tb_inst_rom_srv;

  logic        clk = 1'b0;
  logic        rst, ce, lv, lb_last, reload;
  logic [31:0] addr;
  logic [7:0]  lb;
  logic [31:0] data;
  logic        ready, cpu_rst, done, ferr;

  logic        s_rst, s_ce, s_lv, s_last, s_reload;
  logic [31:0] s_addr;
  logic [7:0]  s_lb;
  logic [31:0] s_data;
  logic        s_ready, s_cpu_rst, s_done, s_ferr;

  always #5 clk = ~clk;

  inst_rom_srv #(.ADDR_W(10)) u_dut (
    .clk(clk), .rst(rst), .rom_ce_i(ce),
    .rom_addr_i(addr), .rom_data_o(data),
    .load_valid_i(lv), .load_byte_i(lb),
    .load_last_i(lb_last), .load_ready_o(ready),
    .reload_req_i(reload), .cpu_rst_o(cpu_rst),
    .load_done_o(done), .fetch_err_o(ferr)
  );

  inst_rom_srv #(.ADDR_W(2)) u_small (
    .clk(clk), .rst(s_rst), .rom_ce_i(s_ce),
    .rom_addr_i(s_addr), .rom_data_o(s_data),
    .load_valid_i(s_lv), .load_byte_i(s_lb),
    .load_last_i(s_last), .load_ready_o(s_ready),
    .reload_req_i(s_reload), .cpu_rst_o(s_cpu_rst),
    .load_done_o(s_done), .fetch_err_o(s_ferr)
  );

  typedef enum int {
    K_DATA, K_CPURST, K_DONE, K_FERR, K_READY,
    K_SDATA, K_SREADY, K_SCPURST
  } kind_e;

  typedef struct {
    kind_e       kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] sample(
    input kind_e k
  );
    case (k)
      K_DATA:   return data;
      K_CPURST: return {31'd0, cpu_rst};
      K_DONE:   return {31'd0, done};
      K_FERR:   return {31'd0, ferr};
      K_READY:  return {31'd0, ready};
      K_SDATA:  return s_data;
      K_SREADY: return {31'd0, s_ready};
      default:  return {31'd0, s_cpu_rst};
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = sample(e.kind);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h",
                 e.name, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(
    input kind_e k,
    input logic [31:0] v,
    input string n
  );
    logic [31:0] act;
    act = sample(k);
    checks++;
    if (act !== v) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               n, act, v);
    end
  endtask

  task automatic wait_sdone(input int max);
    int n;
    n = 0;
    while (s_done !== 1'b1 && n < max) begin
      step();
      n++;
    end
    checks++;
    if (s_done !== 1'b1) begin
      errors++;
      $display("FAIL t3_wait_run: expired");
    end
  endtask

  task automatic expect_v(
    input kind_e k,
    input logic [31:0] v,
    input string n
  );
    exp_t e;
    e.kind = k;
    e.exp  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic send(
    input logic [7:0] b,
    input logic last
  );
    lv = 1'b1; lb = b; lb_last = last;
    step();
    lv = 1'b0; lb_last = 1'b0;
  endtask

  task automatic s_send(input logic [7:0] b);
    s_lv = 1'b1; s_lb = b; s_last = 1'b0;
    step();
    s_lv = 1'b0;
  endtask

  task automatic fetch(
    input logic [31:0] a,
    input logic [31:0] v,
    input string n
  );
    ce = 1'b1; addr = a;
    expect_v(K_DATA, v, n);
    step();
  endtask

  task automatic s_fetch(
    input logic [31:0] a,
    input logic [31:0] v,
    input string n
  );
    s_ce = 1'b1; s_addr = a;
    expect_v(K_SDATA, v, n);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    logic [7:0] img1 [8];
    img1 = '{8'h34, 8'h01, 8'h00, 8'h10,
             8'h34, 8'h02, 8'h00, 8'h20};
    rst = 1'b1; ce = 1'b0; addr = '0;
    lv = 1'b0; lb = '0;
    lb_last = 1'b0; reload = 1'b0;
    s_rst = 1'b1; s_ce = 1'b0; s_addr = '0;
    s_lv = 1'b0; s_lb = '0; s_last = 1'b0;
    s_reload = 1'b0;
    step();
    rst = 1'b0; s_rst = 1'b0;
    step();

    check_now(K_CPURST, 1, "rst_cpu_rst");
    check_now(K_DONE,   0, "rst_load_done");
    check_now(K_FERR,   0, "rst_fetch_err");
    check_now(K_READY,  1, "rst_load_ready");
    fetch(32'h0, 32'h0, "fetch_in_load_nop");

    ce = 1'b0;
    for (int i = 0; i < 8; i++)
      send(img1[i], i == 7);
    expect_v(K_CPURST, 1, "t1_done_cpu_rst");
    expect_v(K_READY,  0, "t1_done_ready");
    step();
    expect_v(K_CPURST, 0, "t1_run_cpu_rst");
    expect_v(K_DONE,   1, "t1_run_load_done");
    fetch(32'h4, 32'h34020020, "t1_fetch4");
    fetch(32'h0, 32'h34010010, "t1_fetch0");
    fetch(32'h7, 32'h34020020, "t1_low_bits");

    ce = 1'b0;
    do_reset();
    send(8'hAA, 0); send(8'hBB, 0);
    send(8'hCC, 0); send(8'hDD, 0);
    send(8'h11, 0); send(8'h22, 1);
    step();
    expect_v(K_DONE, 1, "t2_load_done");
    fetch(32'h0, 32'hAABBCCDD, "t2_fetch0");
    fetch(32'h4, 32'h11220000, "t2_fetch4_zf");

    expect_v(K_FERR, 0, "t4_ferr_before");
    fetch(32'h00001000, 32'h0, "t4_oob_nop");
    ce = 1'b0; addr = 32'h4;
    expect_v(K_FERR, 1, "t4_ferr_set");
    expect_v(K_DATA, 0, "t4_ce0_nop");
    step();
    fetch(32'h0, 32'hAABBCCDD, "t4_fetch_err");
    expect_v(K_FERR, 1, "t4_ferr_sticky");
    step();

    ce = 1'b0;
    send(8'h01, 0);
    expect_v(K_CPURST, 0, "t5_run_ignores");
    step();
    do_reset();
    send(8'h01, 0); send(8'h02, 0);
    do_reset();
    send(8'h12, 0); send(8'h34, 0);
    expect_v(K_CPURST, 1, "t5_cpu_rst_mid");
    send(8'h56, 0); send(8'h78, 1);
    expect_v(K_CPURST, 1, "t5_cpu_rst_done");
    step();
    fetch(32'h0, 32'h12345678, "t5_fetch0");

    ce = 1'b0;
    reload = 1'b1;
    step();
    reload = 1'b0;
`ifdef ROM_RELOAD_EN
    expect_v(K_CPURST, 1, "t6_reload_rst");
    expect_v(K_DONE,   0, "t6_reload_done");
    step();
    send(8'h00, 0); send(8'h00, 0);
    send(8'h00, 0); send(8'h0C, 1);
    step();
    fetch(32'h0, 32'h0000000C, "t6_fetch0");
`else
    expect_v(K_CPURST, 0, "t6_no_reload_rst");
    expect_v(K_DONE,   1, "t6_no_reload_done");
    step();
    fetch(32'h0, 32'h12345678, "t6_fixed");
`endif

    ce = 1'b0;
    for (int i = 1; i <= 15; i++)
      s_send(8'(i));
    expect_v(K_SREADY, 1, "t3_ready_pre16");
    s_send(8'd16);
    expect_v(K_SREADY,  0, "t3_ready_post16");
    expect_v(K_SCPURST, 1, "t3_done_cpu_rst");
    for (int i = 17; i <= 20; i++)
      s_send(8'(i));
    expect_v(K_SREADY,  0, "t3_ready_stall");
    expect_v(K_SCPURST, 0, "t3_run_entered");
    step();
    wait_sdone(8);
    s_fetch(32'h0, 32'h01020304, "t3_mem0");
    s_fetch(32'h4, 32'h05060708, "t3_mem1");
    s_fetch(32'h8, 32'h090A0B0C, "t3_mem2");
    s_fetch(32'hC, 32'h0D0E0F10, "t3_mem3");

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
